// File: rtl/cordic_multimode.sv
// rtl/cordic_multimode.sv - iterative rotation/vectoring CORDIC with quadrant pre-rotation
// One micro-rotation per clock; ready/valid in and out with output backpressure.
module cordic_multimode #(
    parameter int N_FRAC     = 7,
    parameter int ITERATIONS = 6,
    parameter int GUARD      = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                mode_i,
    input  logic [N_FRAC:0]     x_i,
    input  logic [N_FRAC:0]     y_i,
    input  logic [N_FRAC:0]     z_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [N_FRAC:0]     x_o,
    output logic [N_FRAC:0]     y_o,
    output logic [N_FRAC:0]     z_o,
    output logic                busy_o
);
    localparam int W  = N_FRAC + 1;
    localparam int WX = W + GUARD;
    localparam logic [3:0] LAST = 4'(ITERATIONS - 1);
    localparam logic signed [WX-1:0] SAT_HI = WX'((1 << N_FRAC) - 1);
    localparam logic signed [WX-1:0] SAT_LO = WX'(-(1 << N_FRAC));

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_CALC, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic signed [WX-1:0]   x_q, x_d, y_q, y_d;
    logic signed [W-1:0]    z_q, z_d;
    logic                   mode_q, mode_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [W-1:0]           xo_q, xo_d, yo_q, yo_d, zo_q, zo_d;

    logic signed [WX-1:0]   x_ext, y_ext, x_sh, y_sh, x_it, y_it;
    logic signed [W-1:0]    z_it, atan_i;
    logic                   pre_flip, d_pos;

    // Arctangent table at 2^15 scale, rescaled to the angle LSB by truncation.
    function automatic logic [W-1:0] atan_at(input logic [3:0] i);
        logic [15:0] t;
        t = 16'd0;
        case (i)
            4'd0:  t = 16'd8192;
            4'd1:  t = 16'd4836;
            4'd2:  t = 16'd2555;
            4'd3:  t = 16'd1297;
            4'd4:  t = 16'd651;
            4'd5:  t = 16'd326;
            4'd6:  t = 16'd163;
            4'd7:  t = 16'd81;
            4'd8:  t = 16'd41;
            4'd9:  t = 16'd20;
            4'd10: t = 16'd10;
            4'd11: t = 16'd5;
            4'd12: t = 16'd3;
            4'd13: t = 16'd1;
            4'd14: t = 16'd1;
            default: t = 16'd0;
        endcase
        return W'(t >> (15 - N_FRAC));
    endfunction

    function automatic logic [W-1:0] sat(input logic signed [WX-1:0] v);
        if (v > SAT_HI)
            return SAT_HI[W-1:0];
        else if (v < SAT_LO)
            return SAT_LO[W-1:0];
        else
            return v[W-1:0];
    endfunction

    assign x_ext  = {{GUARD{x_i[W-1]}}, x_i};
    assign y_ext  = {{GUARD{y_i[W-1]}}, y_i};
    // Rotation: angle outside [-pi/2, pi/2) when the top two bits differ.
    assign pre_flip = mode_q ? x_q[WX-1] : (z_q[W-1] ^ z_q[W-2]);
    assign d_pos  = mode_q ? y_q[WX-1] : ~z_q[W-1];
    assign x_sh   = x_q >>> cnt_q;
    assign y_sh   = y_q >>> cnt_q;
    assign atan_i = atan_at(cnt_q);
    assign x_it   = d_pos ? (x_q - y_sh) : (x_q + y_sh);
    assign y_it   = d_pos ? (y_q + x_sh) : (y_q - x_sh);
    assign z_it   = d_pos ? (z_q - atan_i) : (z_q + atan_i);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    x_d     = x_ext;
                    y_d     = y_ext;
                    z_d     = z_i;
                    mode_d  = mode_i;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                cnt_d = 4'd0;
                if (pre_flip) begin
                    x_d = -x_q;
                    y_d = -y_q;
                    z_d = {~z_q[W-1], z_q[W-2:0]};
                end
                state_d = S_CALC;
            end
            S_CALC: begin
                x_d = x_it;
                y_d = y_it;
                z_d = z_it;
                if (cnt_q == LAST) begin
                    xo_d    = sat(x_it);
                    yo_d    = sat(y_it);
                    zo_d    = z_it;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= 4'd0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign x_o         = xo_q;
    assign y_o         = yo_q;
    assign z_o         = zo_q;
endmodule

// File: tb/tb_cordic_multimode.sv
// tb/tb_cordic_multimode.sv - self-checking bench for cordic_multimode
module tb_cordic_multimode;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic a_iv, a_ir, a_mode, a_ov, a_or, a_busy;
    logic signed [7:0] a_x, a_y, a_z, a_xo, a_yo, a_zo;
    logic b_iv, b_ir, b_mode, b_ov, b_or, b_busy;
    logic signed [11:0] b_x, b_y, b_z, b_xo, b_yo, b_zo;

    int tests = 0;
    int fails = 0;

    cordic_multimode #(.N_FRAC(7), .ITERATIONS(6), .GUARD(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .in_valid_i(a_iv), .in_ready_o(a_ir), .mode_i(a_mode),
        .x_i(a_x), .y_i(a_y), .z_i(a_z), .out_valid_o(a_ov), .out_ready_i(a_or),
        .x_o(a_xo), .y_o(a_yo), .z_o(a_zo), .busy_o(a_busy));

    cordic_multimode #(.N_FRAC(11), .ITERATIONS(12), .GUARD(2)) dut_b (
        .clk_i(clk), .rst_i(rst), .in_valid_i(b_iv), .in_ready_o(b_ir), .mode_i(b_mode),
        .x_i(b_x), .y_i(b_y), .z_i(b_z), .out_valid_o(b_ov), .out_ready_i(b_or),
        .x_o(b_xo), .y_o(b_yo), .z_o(b_zo), .busy_o(b_busy));

    typedef struct {
        int mode, x, y, z;
        int ex, ey, ez;
        int tx, ty, tz;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp, input int tol);
        tests++;
        if (act < exp - tol || act > exp + tol) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", nm, act, exp, tol);
        end
    endtask

    function automatic int wrap8(input int v);
        return ((v % 256) + 256 + 128) % 256 - 128;
    endfunction

    function automatic int sat8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    // Plain-integer CORDIC reference for the 7-bit / 6-iteration configuration.
    task automatic model(input int mode, input int x, input int y, input int z,
                         output int xo, output int yo, output int zo);
        int tbl[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};
        int xx, yy, zz;
        xx = x; yy = y; zz = z;
        if (mode == 0 ? (z >= 64 || z < -64) : (x < 0)) begin
            xx = -x; yy = -y; zz = wrap8(z + 128);
        end
        for (int i = 0; i < 6; i++) begin
            int a, xs, ys;
            bit dp;
            a  = tbl[i] >>> 8;
            xs = xx >>> i;
            ys = yy >>> i;
            dp = (mode == 0) ? (zz >= 0) : (yy < 0);
            if (dp) begin
                xx = xx - ys; yy = yy + xs; zz = wrap8(zz - a);
            end else begin
                xx = xx + ys; yy = yy - xs; zz = wrap8(zz + a);
            end
        end
        xo = sat8(xx); yo = sat8(yy); zo = zz;
    endtask

    task automatic run_a(input int mode, input int x, input int y, input int z, input int hold,
                         output int xo, output int yo, output int zo, output int lat);
        @(negedge clk);
        a_mode = mode[0]; a_x = 8'(x); a_y = 8'(y); a_z = 8'(z);
        a_iv = 1'b1; a_or = (hold == 0);
        @(posedge clk); #1;
        a_iv = 1'b0;
        lat = 0;
        while (!a_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        xo = int'(a_xo); yo = int'(a_yo); zo = int'(a_zo);
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            @(negedge clk);
            a_or = 1'b1;
        end
        @(posedge clk); #1;
        a_or = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int xo, yo, zo, lat, ex, ey, ez, mode, x, y, z, hold;
        vecs[0] = '{0,  78,   0,   32,   91,  91,   0, 3, 3, 2};
        vecs[1] = '{1, -40,  40,    0,   93,   0,  96, 3, 2, 2};
        vecs[2] = '{1,  40,  40,    0,    0,   0,  32, -1, -1, 2};
        vecs[3] = '{0,  78,   0,   96,  -91,  91,   0, 3, 3, -1};
        vecs[4] = '{0,  78,   0, -128, -128,   0,   0, 0, 3, -1};
        vecs[5] = '{1, 127, 127,    0,  127,   0,  32, 0, -1, 2};
        vecs[6] = '{0,   0,  50,    0,    0,  82,   0, 3, 3, 2};

        rst = 1'b1;
        a_iv = 0; a_or = 0; a_mode = 0; a_x = 0; a_y = 0; a_z = 0;
        b_iv = 0; b_or = 0; b_mode = 0; b_x = 0; b_y = 0; b_z = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(a_ir), 1, 0);
        chk("reset_out_valid", int'(a_ov), 0, 0);
        chk("reset_busy", int'(a_busy), 0, 0);
        chk("reset_x_o", int'(a_xo), 0, 0);
        chk("reset_y_o", int'(a_yo), 0, 0);
        chk("reset_z_o", int'(a_zo), 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_a(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].z, 0, xo, yo, zo, lat);
            chk($sformatf("vec%0d_latency", i), lat, 7, 0);
            if (vecs[i].tx >= 0) chk($sformatf("vec%0d_x", i), xo, vecs[i].ex, vecs[i].tx);
            if (vecs[i].ty >= 0) chk($sformatf("vec%0d_y", i), yo, vecs[i].ey, vecs[i].ty);
            if (vecs[i].tz >= 0) chk($sformatf("vec%0d_z", i), zo, vecs[i].ez, vecs[i].tz);
            chk($sformatf("vec%0d_valid_pulse", i), int'(a_ov), 0, 0);
            chk($sformatf("vec%0d_ready_back", i), int'(a_ir), 1, 0);
        end

        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 1));
            x = int'($urandom_range(0, 255)) - 128;
            y = int'($urandom_range(0, 255)) - 128;
            z = int'($urandom_range(0, 255)) - 128;
            hold = int'($urandom_range(0, 3));
            model(mode, x, y, z, ex, ey, ez);
            run_a(mode, x, y, z, hold, xo, yo, zo, lat);
            chk($sformatf("rnd%0d_latency", n), lat, 7, 0);
            chk($sformatf("rnd%0d_x", n), xo, ex, 0);
            chk($sformatf("rnd%0d_y", n), yo, ey, 0);
            chk($sformatf("rnd%0d_z", n), zo, ez, 0);
        end

        // Backpressure: result held for 5 cycles, stray in_valid ignored.
        model(1, 60, -70, 5, ex, ey, ez);
        @(negedge clk);
        a_mode = 1'b1; a_x = 8'(60); a_y = -8'sd70; a_z = 8'(5); a_iv = 1'b1; a_or = 1'b0;
        @(posedge clk); #1;
        a_iv = 1'b0;
        lat = 0;
        while (!a_ov && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_latency", lat, 7, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 2) begin
                a_iv = 1'b1; a_mode = 1'b0; a_x = 8'(11); a_y = 8'(22); a_z = 8'(33);
            end
            @(posedge clk); #1;
            a_iv = 1'b0;
            chk($sformatf("bp%0d_valid", k), int'(a_ov), 1, 0);
            chk($sformatf("bp%0d_ready", k), int'(a_ir), 0, 0);
            chk($sformatf("bp%0d_x", k), int'(a_xo), ex, 0);
            chk($sformatf("bp%0d_y", k), int'(a_yo), ey, 0);
            chk($sformatf("bp%0d_z", k), int'(a_zo), ez, 0);
        end
        @(negedge clk);
        a_or = 1'b1;
        @(posedge clk); #1;
        a_or = 1'b0;
        chk("bp_release_valid", int'(a_ov), 0, 0);
        chk("bp_release_ready", int'(a_ir), 1, 0);
        chk("bp_release_x", int'(a_xo), ex, 0);
        chk("bp_release_z", int'(a_zo), ez, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("bp_no_phantom_valid", int'(a_ov), 0, 0);
        chk("bp_no_phantom_busy", int'(a_busy), 0, 0);

        // Asynchronous reset while the counter is at 3.
        @(negedge clk);
        a_mode = 1'b0; a_x = 8'(78); a_y = 8'(0); a_z = 8'(32); a_iv = 1'b1; a_or = 1'b1;
        @(posedge clk); #1;
        a_iv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_before_reset", int'(a_busy), 1, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid_reset_in_ready", int'(a_ir), 1, 0);
        chk("mid_reset_out_valid", int'(a_ov), 0, 0);
        chk("mid_reset_busy", int'(a_busy), 0, 0);
        chk("mid_reset_x_o", int'(a_xo), 0, 0);
        chk("mid_reset_y_o", int'(a_yo), 0, 0);
        chk("mid_reset_z_o", int'(a_zo), 0, 0);
        @(negedge clk);
        rst = 1'b0;
        a_or = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_no_valid_after_abort", int'(a_ov), 0, 0);
        model(0, 78, 0, 32, ex, ey, ez);
        run_a(0, 78, 0, 32, 1, xo, yo, zo, lat);
        chk("post_reset_latency", lat, 7, 0);
        chk("post_reset_x", xo, ex, 0);
        chk("post_reset_y", yo, ey, 0);
        chk("post_reset_z", zo, ez, 0);

        // Wide configuration: 11 fractional bits, 12 iterations.
        @(negedge clk);
        b_mode = 1'b0; b_x = 12'(1243); b_y = 12'(0); b_z = 12'(512); b_iv = 1'b1; b_or = 1'b1;
        @(posedge clk); #1;
        b_iv = 1'b0;
        lat = 0;
        while (!b_ov && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("wide_latency", lat, 13, 0);
        chk("wide_x", int'(b_xo), 1448, 8);
        chk("wide_y", int'(b_yo), 1448, 8);
        @(posedge clk); #1;
        b_or = 1'b0;
        chk("wide_ready_back", int'(b_ir), 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
